puf_challenge_sequencer: RTL and testbench

Challenge-side controller for the 4-bit arbiter PUF array. On a start pulse it steps through a 16-bit LFSR challenge sequence and drives each challenge onto the PUF switch inputs. For each challenge it waits for the arbiters to settle, samples the 4-bit response several times and majority-votes each bit. Each voted challenge/response pair is streamed out over a valid/ready interface to the enrollment/UART logic.

---
 rtl/puf_pkg.sv | 25 ++
 rtl/puf_lfsr16.sv | 36 +++
 rtl/puf_challenge_sequencer.sv | 136 +++++++++++++
 tb/tb_puf_challenge_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared definitions for the PUF challenge sequencer: FSM encoding, LFSR mask,
// pair field widths and the Galois LFSR step function.
package puf_pkg;

  localparam int CHAL_W = 16;
  localparam int RESP_W = 4;
  localparam int DATA_W = CHAL_W + RESP_W;

  localparam logic [CHAL_W-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    EMIT,
    DONE
  } state_e;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  function automatic logic [CHAL_W-1:0] lfsrNext(input logic [CHAL_W-1:0] v);
    lfsrNext = {1'b0, v[CHAL_W-1:1]} ^ (v[0] ? LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/puf_lfsr16.sv
// 16-bit Galois LFSR holding the current challenge; load restarts from SEED,
// step advances one position.
module puf_lfsr16
  import puf_pkg::*;
#(
  parameter logic [CHAL_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  output logic [CHAL_W-1:0] value
);

  logic [CHAL_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = SEED;
    end else if (step) begin
      value_d = lfsrNext(value_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Drives LFSR challenges into the arbiter PUF, majority-votes repeated samples and
// streams {challenge, voted} pairs. Define PUF_SEQ_STABILITY_EN for per-bit unanimity flags.
module puf_challenge_sequencer
  import puf_pkg::*;
#(
  parameter int                SETTLE_CYCLES  = 16,
  parameter int                EVALS          = 7,
  parameter int                NUM_CHALLENGES = 256,
  parameter logic [CHAL_W-1:0] LFSR_SEED      = 16'hACE1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [CHAL_W-1:0] challenge,
  input  logic [RESP_W-1:0] response,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RESP_W-1:0] out_stable
);

  localparam int CNT_W = $clog2(EVALS + 1);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int IDX_W = (NUM_CHALLENGES > 1) ? $clog2(NUM_CHALLENGES) : 1;
  localparam logic [CNT_W-1:0] HALF = CNT_W'(EVALS / 2);

  state_e                        state_q, state_d;
  logic [RESP_W-1:0]             syncMeta_q, syncResp_q;
  logic [SET_W-1:0]              settleCnt_q, settleCnt_d;
  logic [CNT_W-1:0]              sampleCnt_q, sampleCnt_d;
  logic [RESP_W-1:0][CNT_W-1:0]  votes_q, votes_d;
  logic [IDX_W-1:0]              index_q, index_d;
  logic                          lfsrLoad, lfsrStep, handshake, lastChallenge;
  logic [RESP_W-1:0]             voted;

  puf_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (CLK),
    .rst   (RST),
    .load  (lfsrLoad),
    .step  (lfsrStep),
    .value (challenge)
  );

  assign handshake     = (state_q == EMIT) && out_ready;
  assign lastChallenge = (index_q == IDX_W'(NUM_CHALLENGES - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      syncMeta_q  <= '0;
      syncResp_q  <= '0;
      settleCnt_q <= '0;
      sampleCnt_q <= '0;
      votes_q     <= '0;
      index_q     <= '0;
    end else begin
      state_q     <= state_d;
      syncMeta_q  <= response;
      syncResp_q  <= syncMeta_q;
      settleCnt_q <= settleCnt_d;
      sampleCnt_q <= sampleCnt_d;
      votes_q     <= votes_d;
      index_q     <= index_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = APPLY;
      APPLY:   state_d = SETTLE;
      SETTLE:  if (settleCnt_q == SET_W'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
      SAMPLE:  state_d = (sampleCnt_q == CNT_W'(EVALS - 1)) ? EMIT : SETTLE;
      EMIT:    if (out_ready) state_d = lastChallenge ? DONE : APPLY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Settle counter is zero on every entry to SETTLE, so it only counts while staying there.
  always_comb begin
    settleCnt_d = '0;
    sampleCnt_d = sampleCnt_q;
    votes_d     = votes_q;
    index_d     = index_q;
    lfsrLoad    = 1'b0;
    lfsrStep    = handshake;
    if (state_q == SETTLE && state_d == SETTLE) begin
      settleCnt_d = settleCnt_q + SET_W'(1);
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          lfsrLoad = 1'b1;
          index_d  = '0;
        end
      end
      APPLY: begin
        sampleCnt_d = '0;
        votes_d     = '0;
      end
      SAMPLE: begin
        for (int i = 0; i < RESP_W; i++) begin
          votes_d[i] = votes_q[i] + CNT_W'(syncResp_q[i]);
        end
        sampleCnt_d = sampleCnt_q + CNT_W'(1);
      end
      EMIT: begin
        if (out_ready) index_d = index_q + IDX_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    out_valid = (state_q == EMIT);
    voted     = '0;
    for (int i = 0; i < RESP_W; i++) begin
      voted[i] = (votes_q[i] > HALF);
    end
    out_data   = out_valid ? {challenge, voted} : '0;
    out_stable = '0;
`ifdef PUF_SEQ_STABILITY_EN
    if (out_valid) begin
      for (int i = 0; i < RESP_W; i++) begin
        out_stable[i] = (votes_q[i] == '0) || (votes_q[i] == CNT_W'(EVALS));
      end
    end
`endif
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Randomized bench for puf_challenge_sequencer with a timeline-based reference model;
// define PUF_SEQ_STABILITY_EN to also check the unanimity flags.
`timescale 1ns/1ps
module tb_puf_challenge_sequencer;

  localparam int SETTLE = 16;
  localparam int EVALS  = 7;
  localparam int NCH    = 4;
  localparam logic [15:0] SEED = 16'hACE1;
  // Cycles from the APPLY cycle to the first EMIT cycle of a challenge.
  localparam int SPAN = 1 + EVALS * (SETTLE + 1);

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic        out_ready = 1'b1;
  logic [3:0]  response;
  logic        busy, done, out_valid;
  logic [15:0] challenge;
  logic [19:0] out_data;
  logic [3:0]  out_stable;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  bit          mRun = 1'b0;
  bit          mEmit = 1'b0;
  bit          mDonePulse = 1'b0;
  logic [15:0] mLfsr = SEED;
  int          mIdx = 0;
  int          mApply = 0;
  logic [3:0]  samp [EVALS];
  int          noiseMode = 0;
  logic [19:0] pairs [$];
  int          doneCount = 0;
  int          t0;
  bit          ok;

  puf_challenge_sequencer #(
    .SETTLE_CYCLES  (SETTLE),
    .EVALS          (EVALS),
    .NUM_CHALLENGES (NCH),
    .LFSR_SEED      (SEED)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .challenge  (challenge),
    .response   (response),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_stable (out_stable)
  );

  initial forever #5 CLK = ~CLK;

  function automatic logic [15:0] galois(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3:0] pufOf(input logic [15:0] c);
    return c[3:0] ^ c[7:4];
  endfunction

  function automatic int onesOf(input int b);
    int n;
    n = 0;
    for (int k = 0; k < EVALS; k++) if (samp[k][b]) n++;
    return n;
  endfunction

  function automatic logic [3:0] expVoted();
    logic [3:0] v;
    v = '0;
    for (int b = 0; b < 4; b++) v[b] = (onesOf(b) > EVALS / 2);
    return v;
  endfunction

  function automatic logic [3:0] expStable();
    logic [3:0] v;
    v = '0;
`ifdef PUF_SEQ_STABILITY_EN
    for (int b = 0; b < 4; b++) v[b] = (onesOf(b) == 0) || (onesOf(b) == EVALS);
`endif
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic failTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  task automatic applyStimulus(input logic startVal, input logic readyVal);
    @(posedge CLK);
    #1;
    start     = startVal;
    out_ready = readyVal;
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic waitValid(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  task automatic waitDone(input int budget, input bit randomize, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (randomize) applyStimulus(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
      tick();
      if (done) begin
        found = 1'b1;
        break;
      end
    end
  endtask

  // Reference model: a run is a sequence of fixed-length challenge windows starting at
  // mApply; the window ends in EMIT, which lasts until the consumer accepts.
  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) begin
      mRun = 1'b0; mEmit = 1'b0; mDonePulse = 1'b0;
      mLfsr = SEED; mIdx = 0; mApply = 0;
    end else if (mDonePulse) begin
      mDonePulse = 1'b0;
      mRun = 1'b0;
    end else if (!mRun) begin
      if (start) begin
        mRun = 1'b1; mLfsr = SEED; mIdx = 0; mApply = cyc + 1;
      end
    end else if (mEmit) begin
      if (out_ready) begin
        mEmit = 1'b0;
        mLfsr = galois(mLfsr);
        mIdx++;
        if (mIdx == NCH) mDonePulse = 1'b1;
        else mApply = cyc + 1;
      end
    end else if (cyc + 1 - mApply == SPAN) begin
      mEmit = 1'b1;
    end
  end

  // PUF model: each sample's value is held from 8 cycles before its sampling cycle.
  initial begin
    int rel;
    logic [3:0] base;
    response = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (mRun && !mEmit && !mDonePulse && !RST) begin
        rel  = cyc + 1 - mApply;
        base = pufOf(mLfsr);
        if (rel == 0) begin
          for (int k = 0; k < EVALS; k++) begin
            case (noiseMode)
              1:       samp[k] = base ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
              2:       samp[k] = {base[3:1], (k < 3)};
              default: samp[k] = base;
            endcase
          end
        end
        if (rel >= 9 && (rel - 9) % (SETTLE + 1) == 0 && (rel - 9) / (SETTLE + 1) < EVALS) begin
          response = samp[(rel - 9) / (SETTLE + 1)];
        end
      end
    end
  end

  initial forever begin
    @(negedge CLK);
    cyc++;
    checkOutput("busy", 32'(busy), 32'(mRun));
    checkOutput("done", 32'(done), 32'(mDonePulse));
    checkOutput("out_valid", 32'(out_valid), 32'(mEmit));
    checkOutput("challenge", 32'(challenge), 32'(mLfsr));
    checkOutput("out_data", 32'(out_data), mEmit ? 32'({mLfsr, expVoted()}) : 32'h0);
    checkOutput("out_stable", 32'(out_stable), mEmit ? 32'(expStable()) : 32'h0);
    if (!RST && out_valid && out_ready) pairs.push_back(out_data);
    if (!RST && done) doneCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with start held high must leave the sequencer idle.
    RST = 1'b1; start = 1'b1; out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_valid", 32'(out_valid), 32'h0);
    checkOutput("rst_challenge", 32'(challenge), 32'hACE1);
    @(posedge CLK); #1; RST = 1'b0; start = 1'b0;
    repeat (3) tick();

    // Run 1: clean responses, start held high through the whole run including DONE.
    noiseMode = 0;
    applyStimulus(1'b1, 1'b1);
    t0 = cyc + 1;
    waitValid(300, ok);
    if (!ok) failTimeout("run1_first_valid");
    else begin
      checkOutput("first_valid_cycle", 32'(cyc), 32'(t0 + 121));
      checkOutput("first_pair", 32'(out_data), 32'hACE1F);
    end
    waitDone(1000, 1'b0, ok);
    if (!ok) failTimeout("run1_done");
    applyStimulus(1'b0, 1'b1);
    repeat (5) tick();
    checkOutput("run1_busy_after", 32'(busy), 32'h0);
    checkOutput("run1_pairs", 32'(pairs.size()), 32'(NCH));
    checkOutput("run1_done_count", 32'(doneCount), 32'h1);
    if (pairs.size() == NCH) begin
      checkOutput("pair1_chal", 32'(pairs[1][19:4]), 32'hE270);
      checkOutput("pair2_chal", 32'(pairs[2][19:4]), 32'h7138);
      checkOutput("pair3_chal", 32'(pairs[3][19:4]), 32'h389C);
    end

    // Run 2: noisy bit 0 and a long stall, then random backpressure and start pulses.
    pairs.delete(); doneCount = 0; noiseMode = 2;
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
    waitValid(300, ok);
    if (!ok) failTimeout("run2_first_valid");
    else begin
      checkOutput("noisy_pair", 32'(out_data), 32'hACE1E);
`ifdef PUF_SEQ_STABILITY_EN
      checkOutput("noisy_stable", 32'(out_stable), 32'hE);
`else
      checkOutput("noisy_stable", 32'(out_stable), 32'h0);
`endif
      repeat (50) tick();
      checkOutput("stall_valid", 32'(out_valid), 32'h1);
      checkOutput("stall_data", 32'(out_data), 32'hACE1E);
      checkOutput("stall_challenge", 32'(challenge), 32'hACE1);
    end
    noiseMode = 1;
    waitDone(3000, 1'b1, ok);
    if (!ok) failTimeout("run2_done");
    applyStimulus(1'b0, 1'b1);
    repeat (5) tick();
    checkOutput("run2_pairs", 32'(pairs.size()), 32'(NCH));
    checkOutput("run2_done_count", 32'(doneCount), 32'h1);
    checkOutput("run2_busy_after", 32'(busy), 32'h0);

    // Run 3: reset in the middle of settling on the third challenge, then restart.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (mRun && !mEmit && mIdx == 2 && cyc - mApply == 5) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) failTimeout("run3_mid_settle");
    @(posedge CLK); #1; RST = 1'b1;
    tick();
    checkOutput("midrst_busy", 32'(busy), 32'h0);
    checkOutput("midrst_challenge", 32'(challenge), 32'hACE1);
    @(posedge CLK); #1; RST = 1'b0;
    repeat (3) tick();
    pairs.delete(); doneCount = 0;
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    waitValid(300, ok);
    if (!ok) failTimeout("run3_first_valid");
    else checkOutput("restart_chal", 32'(out_data[19:4]), 32'hACE1);
    waitDone(1000, 1'b0, ok);
    if (!ok) failTimeout("run3_done");
    repeat (5) tick();
    checkOutput("run3_pairs", 32'(pairs.size()), 32'(NCH));
    checkOutput("run3_done_count", 32'(doneCount), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
